// File: rtl/spi_cmd_ctrl.sv
// Register-access command sequencer in front of the 16-bit SPI master: queues
// read/write requests, runs one frame at a time and returns one response per request.
module spi_cmd_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int FIFO_AW     = 2,
    parameter int TIMEOUT_CYC = 4095,
    parameter int GAP_CYC     = 50
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [1:0]  cfg_mode,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [6:0]  req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        spi_en,
    output logic [1:0]  spi_mode,
    output logic [15:0] spi_sdata,
    input  logic [15:0] spi_rdata,
    input  logic        spi_done
);

    localparam logic [FIFO_AW:0] LP_DEPTH    = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0]      LP_TO_LAST  = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0]      LP_GAP_LAST = 16'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_DONE,
        S_RESP,
        S_GAP
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [15:0]          r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_count;
    logic [15:0]          r_entry;
    logic [15:0]          r_cnt;
    logic [7:0]           r_rdata;
    logic                 r_err;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_mode_ok;
    logic [15:0]          w_frame;
    logic                 w_unused;

    assign w_full    = (r_count == LP_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_push    = req_valid && !w_full;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign w_mode_ok = (cfg_mode == 2'd1) || (cfg_mode == 2'd3);
    assign w_frame   = {r_entry[15], r_entry[14:8], r_entry[15] ? 8'h00 : r_entry[7:0]};
    // Only the low byte of the received frame carries register data.
    assign w_unused  = ^spi_rdata[15:8];

    assign req_ready = !w_full;
    assign busy      = (r_state != S_IDLE) || !w_empty;

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_rw, req_addr, req_wdata};
        end
        if (w_pop) begin
            r_entry <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (!w_empty) w_next = S_LOAD;
            S_LOAD:      w_next = w_mode_ok ? S_WAIT_DONE : S_RESP;
            // A completion in the timeout cycle still counts as a good frame.
            S_WAIT_DONE: if (spi_done || (r_cnt == LP_TO_LAST)) w_next = S_RESP;
            S_RESP:      w_next = S_GAP;
            S_GAP:       if (r_cnt == LP_GAP_LAST) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_en    <= 1'b0;
            spi_mode  <= 2'd1;
            spi_sdata <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    spi_sdata <= w_frame;
                    spi_mode  <= cfg_mode;
                    r_cnt     <= '0;
                    if (w_mode_ok) begin
                        spi_en <= 1'b1;
                    end else begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                S_WAIT_DONE: begin
                    if (spi_done) begin
                        spi_en  <= 1'b0;
                        r_err   <= 1'b0;
                        r_rdata <= spi_sdata[15] ? spi_rdata[7:0] : 8'h00;
                    end else if (r_cnt == LP_TO_LAST) begin
                        spi_en  <= 1'b0;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= r_rdata;
                    rsp_err   <= r_err;
                    r_cnt     <= '0;
                end
                S_GAP: begin
                    r_cnt <= r_cnt + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: directed scenarios plus a randomized phase, scored
// against a request-level model (ordered request queue, one response each).
module tb_spi_cmd_ctrl;

    localparam int FIFO_DEPTH  = 4;
    localparam int FIFO_AW     = 2;
    localparam int TIMEOUT_CYC = 4095;
    localparam int GAP_CYC     = 50;

    typedef struct packed {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [1:0]  mode;
        logic        hang;
        logic [15:0] rdata;
    } req_t;

    logic        sys_clk;
    logic        rst_n;
    logic [1:0]  cfg_mode;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [6:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        spi_en;
    logic [1:0]  spi_mode;
    logic [15:0] spi_sdata;
    logic [15:0] spi_rdata;
    logic        spi_done;
    logic        stray_done;

    req_t req_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_rsp     = 0;
    int   n_exp_rsp = 0;

    spi_cmd_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .GAP_CYC    (GAP_CYC)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .cfg_mode (cfg_mode),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rw   (req_rw),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .spi_en   (spi_en),
        .spi_mode (spi_mode),
        .spi_sdata(spi_sdata),
        .spi_rdata(spi_rdata),
        .spi_done (spi_done)
    );

    initial begin
        sys_clk = 1'b0;
        forever #10 sys_clk = ~sys_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic mode_ok(input logic [1:0] m);
        return (m == 2'd1) || (m == 2'd3);
    endfunction

    function automatic logic [15:0] exp_frame(input req_t r);
        return {r.rw, r.addr, r.rw ? 8'h00 : r.wdata};
    endfunction

    function automatic logic exp_err(input req_t r);
        return !mode_ok(r.mode) || r.hang;
    endfunction

    function automatic logic [7:0] exp_rdata(input req_t r);
        return (exp_err(r) || !r.rw) ? 8'h00 : r.rdata[7:0];
    endfunction

    // SPI master stand-in plus response scoreboard, sampling 2 ns after each edge.
    initial begin : slave_mon
        req_t cur;
        req_t r;
        int   hi_cnt;
        int   low_cnt;
        int   done_in;
        int   rsp_due;
        bit   prev_en;
        bit   seen_frame;
        bit   frame_act;
        bit   done_chk;
        cur = '0; r = '0;
        hi_cnt = 0; low_cnt = 0; done_in = -1; rsp_due = 0;
        prev_en = 0; seen_frame = 0; frame_act = 0; done_chk = 0;
        spi_done = 1'b0;
        spi_rdata = '0;
        forever begin
            @(posedge sys_clk);
            #2;
            spi_done  = stray_done;
            spi_rdata = 16'($urandom);
            if (!rst_n) begin
                prev_en = 0; seen_frame = 0; frame_act = 0; done_chk = 0;
                done_in = -1; rsp_due = 0;
            end else begin
                if (done_chk) begin
                    check_eq("en_drop", spi_en, 0);
                    done_chk = 0;
                end
                if (rsp_due > 0) begin
                    rsp_due--;
                    if (rsp_due == 0) check_eq("rsp_lat", rsp_valid, 1);
                end
                if (rsp_valid) begin
                    if (req_q.size() == 0) begin
                        check_eq("rsp_spurious", rsp_valid, 0);
                    end else begin
                        r = req_q.pop_front();
                        n_rsp++;
                        check_eq("rsp_err", rsp_err, exp_err(r));
                        check_eq("rsp_rdata", rsp_rdata, exp_rdata(r));
                    end
                end
                if (spi_en && !prev_en) begin
                    if (req_q.size() == 0) begin
                        check_eq("en_spurious", spi_en, 0);
                    end else begin
                        cur = req_q[0];
                        frame_act = 1;
                        check_eq("en_legal", spi_en, mode_ok(cur.mode));
                        check_eq("frame", spi_sdata, exp_frame(cur));
                        check_eq("mode", spi_mode, cur.mode);
                        if (seen_frame) check_eq("gap_min", low_cnt >= GAP_CYC, 1);
                        hi_cnt = 0;
                        done_in = cur.hang ? -1 : int'($urandom_range(0, 5));
                    end
                    seen_frame = 1;
                end
                if (spi_en) begin
                    hi_cnt++;
                    if (frame_act) begin
                        if (hi_cnt > 1)
                            check_eq("frame_hold", {spi_mode, spi_sdata}, {cur.mode, exp_frame(cur)});
                        if (done_in == 0) begin
                            spi_done  = 1'b1;
                            spi_rdata = cur.rdata;
                            done_chk  = 1;
                            done_in   = -1;
                        end else if (done_in > 0) begin
                            done_in--;
                        end
                    end
                end else begin
                    if (prev_en) begin
                        if (frame_act && cur.hang) check_eq("to_len", hi_cnt, TIMEOUT_CYC);
                        rsp_due   = 1;
                        frame_act = 0;
                        low_cnt   = 0;
                    end
                    low_cnt++;
                end
                prev_en = spi_en;
            end
        end
    end

    task automatic push_req(input logic rw, input logic [6:0] addr, input logic [7:0] wd,
                            input logic hang, input logic [15:0] rd);
        req_t r;
        int   w;
        w = 0;
        while (!req_ready && w < 12000) begin
            @(posedge sys_clk); #1;
            w++;
        end
        if (!req_ready) begin
            check_eq("push_wait", req_ready, 1);
        end else begin
            r.rw = rw; r.addr = addr; r.wdata = wd;
            r.mode = cfg_mode; r.hang = hang; r.rdata = rd;
            req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
            req_q.push_back(r);
            n_exp_rsp++;
            @(posedge sys_clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (req_q.size() != 0 && w < 12000) begin
            @(posedge sys_clk); #1;
            w++;
        end
        check_eq("drain", req_q.size(), 0);
        repeat (GAP_CYC + 4) @(posedge sys_clk);
        #1;
        check_eq("busy_idle", busy, 0);
        check_eq("ready_idle", req_ready, 1);
    endtask

    initial begin : watchdog
        #1_200_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n0;
        int hang_budget;
        rst_n = 1'b0; cfg_mode = 2'd3; req_valid = 1'b0; req_rw = 1'b0;
        req_addr = '0; req_wdata = '0; stray_done = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_mode", spi_mode, 2'd1);
        check_eq("rst_en", spi_en, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_outs", {rsp_valid, rsp_err, rsp_rdata, spi_sdata}, 0);
        rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // Write frame and request-to-spi_en latency
        cfg_mode = 2'd3;
        push_req(1'b0, 7'h12, 8'hA5, 1'b0, 16'($urandom));
        check_eq("t1_en_n0", spi_en, 0);
        check_eq("t1_busy", busy, 1);
        @(posedge sys_clk); #1;
        check_eq("t1_en_n1", spi_en, 0);
        @(posedge sys_clk); #1;
        check_eq("t1_en_n2", spi_en, 1);
        check_eq("t1_sdata", spi_sdata, 16'h12A5);
        check_eq("t1_mode", spi_mode, 2'd3);
        drain();
        check_eq("t1_rsp", {rsp_err, rsp_rdata}, 9'h000);

        // Read frame
        cfg_mode = 2'd1;
        push_req(1'b1, 7'h05, 8'($urandom), 1'b0, 16'h003C);
        repeat (2) @(posedge sys_clk);
        #1;
        check_eq("t2_sdata", spi_sdata, 16'h8500);
        check_eq("t2_mode", spi_mode, 2'd1);
        drain();
        check_eq("t2_rdata_hold", rsp_rdata, 8'h3C);
        check_eq("t2_err", rsp_err, 0);

        // Back-to-back, FIFO fills while the first frame is in flight
        cfg_mode = 2'd3;
        n0 = n_rsp;
        for (int i = 0; i < 5; i++)
            push_req(1'($urandom), 7'($urandom), 8'($urandom), 1'b0, 16'($urandom));
        check_eq("t3_ready_full", req_ready, 0);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h7F; req_wdata = 8'hEE;
        @(posedge sys_clk); #1;
        req_valid = 1'b0;
        check_eq("t3_ready_still", req_ready, 0);
        drain();
        check_eq("t3_rsp_cnt", n_rsp - n0, 5);

        // Timeout followed by a normal frame
        n0 = n_rsp;
        push_req(1'b1, 7'h33, 8'h00, 1'b1, 16'($urandom));
        push_req(1'b1, 7'h34, 8'h00, 1'b0, 16'h00C3);
        drain();
        check_eq("t4_rsp_cnt", n_rsp - n0, 2);
        check_eq("t4_last", {rsp_err, rsp_rdata}, 9'h0C3);

        // Illegal mode
        cfg_mode = 2'd2;
        push_req(1'b0, 7'h40, 8'h5A, 1'b0, 16'($urandom));
        drain();
        check_eq("t5_err", rsp_err, 1);
        check_eq("t5_rdata", rsp_rdata, 0);
        check_eq("t5_mode_latched", spi_mode, 2'd2);

        // Reset while waiting on a frame with two more queued
        cfg_mode = 2'd3;
        push_req(1'b0, 7'h01, 8'h11, 1'b1, 16'($urandom));
        push_req(1'b1, 7'h02, 8'h22, 1'b0, 16'($urandom));
        push_req(1'b0, 7'h03, 8'h33, 1'b0, 16'($urandom));
        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("t6_inflight", spi_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_en", spi_en, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_ready", req_ready, 1);
        check_eq("t6_mode", spi_mode, 2'd1);
        check_eq("t6_outs", {rsp_valid, rsp_err, rsp_rdata, spi_sdata}, 0);
        n_exp_rsp = n_exp_rsp - req_q.size();
        req_q.delete();
        repeat (2) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        @(posedge sys_clk); #1;
        stray_done = 1'b1;
        @(posedge sys_clk); #1;
        stray_done = 1'b0;
        repeat (10) @(posedge sys_clk);
        #1;
        check_eq("t6_post_busy", busy, 0);
        check_eq("t6_post_ready", req_ready, 1);
        check_eq("t6_post_en", spi_en, 0);

        // Randomized batches; mode changes only between drained batches
        hang_budget = 2;
        for (int b = 0; b < 6; b++) begin
            cfg_mode = 2'($urandom_range(1, 3));
            for (int i = 0; i < 5; i++) begin
                logic hg;
                hg = (hang_budget > 0) && ($urandom_range(0, 15) == 0);
                if (hg) hang_budget--;
                push_req(1'($urandom), 7'($urandom), 8'($urandom), hg, 16'($urandom));
                repeat ($urandom_range(0, 2)) @(posedge sys_clk);
                #1;
            end
            drain();
        end

        check_eq("rsp_total", n_rsp, n_exp_rsp);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
